// File: rtl/sdram_uart_dump.sv
// Streams WORDS_PER_FRAME words from the SDRAM read FIFO out of a UART as A5 5A hi lo ... frames.
// Optional checksum trailer byte when DUMP_CHECKSUM_EN is defined.
module sdram_uart_dump #(
    parameter int          WORDS_PER_FRAME = 256,
    parameter logic [7:0]  CMD_BYTE        = 8'h52
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        recv_done,
    input  logic [7:0]  recv_data,
    input  logic        sdram_init_done,
    output logic        rd_en,
    input  logic [15:0] rd_data,
    input  logic        tx_busy,
    output logic        send_en,
    output logic [7:0]  send_data,
    output logic        busy,
    output logic        frame_done
);

    localparam int             CW       = $clog2(WORDS_PER_FRAME + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WORDS_PER_FRAME);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic [3:0] {
        IDLE, HDR0, HDR1, POP, CAP, BYTE_HI, BYTE_LO,
`ifdef DUMP_CHECKSUM_EN
        TRAILER,
`endif
        DONE
    } state_t;

    // Per-byte handshake with the transmitter: wait idle, pulse, see busy rise, see busy fall.
    typedef enum logic [1:0] {
        TX_WAIT_IDLE, TX_WAIT_BUSY, TX_WAIT_DONE
    } tx_phase_t;

    state_t          state;
    state_t          next_after_byte_s;
    tx_phase_t       phase;
    logic [CW-1:0]   cnt;
    logic [15:0]     hold;
    logic [7:0]      tx_byte_s;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]      checksum;
`endif

    // Byte presented to the transmitter in each sending state.
    always_comb begin
        tx_byte_s = 8'h00;
        case (state)
            HDR0:    tx_byte_s = 8'hA5;
            HDR1:    tx_byte_s = 8'h5A;
            BYTE_HI: tx_byte_s = hold[15:8];
            BYTE_LO: tx_byte_s = hold[7:0];
`ifdef DUMP_CHECKSUM_EN
            TRAILER: tx_byte_s = checksum;
`endif
            default: tx_byte_s = 8'h00;
        endcase
    end

    // State that follows once the current byte has fully left the transmitter.
    always_comb begin
        next_after_byte_s = IDLE;
        case (state)
            HDR0:    next_after_byte_s = HDR1;
            HDR1:    next_after_byte_s = POP;
            BYTE_HI: next_after_byte_s = BYTE_LO;
            BYTE_LO: begin
                if (cnt == LAST_CNT) begin
`ifdef DUMP_CHECKSUM_EN
                    next_after_byte_s = TRAILER;
`else
                    next_after_byte_s = DONE;
`endif
                end else begin
                    next_after_byte_s = POP;
                end
            end
`ifdef DUMP_CHECKSUM_EN
            TRAILER: next_after_byte_s = DONE;
`endif
            default: next_after_byte_s = IDLE;
        endcase
    end

    // Frame sequencer with registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            phase      <= TX_WAIT_IDLE;
            rd_en      <= 1'b0;
            send_en    <= 1'b0;
            send_data  <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cnt        <= '0;
            hold       <= 16'h0000;
`ifdef DUMP_CHECKSUM_EN
            checksum   <= 8'h00;
`endif
        end else begin
            rd_en      <= 1'b0;
            send_en    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    phase <= TX_WAIT_IDLE;
                    if (recv_done && (recv_data == CMD_BYTE) && sdram_init_done) begin
                        state    <= HDR0;
                        busy     <= 1'b1;
                        cnt      <= '0;
`ifdef DUMP_CHECKSUM_EN
                        checksum <= 8'h00;
`endif
                    end else begin
                        busy <= 1'b0;
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                HDR0, HDR1, BYTE_HI, BYTE_LO, TRAILER: begin
`else
                HDR0, HDR1, BYTE_HI, BYTE_LO: begin
`endif
                    case (phase)
                        TX_WAIT_IDLE: begin
                            if (!tx_busy) begin
                                send_en   <= 1'b1;
                                send_data <= tx_byte_s;
                                phase     <= TX_WAIT_BUSY;
                            end
                        end
                        TX_WAIT_BUSY: begin
                            if (tx_busy) begin
                                phase <= TX_WAIT_DONE;
                            end
                        end
                        TX_WAIT_DONE: begin
                            if (!tx_busy) begin
                                phase <= TX_WAIT_IDLE;
                                state <= next_after_byte_s;
                                // rd_en is raised on entry so the pulse coincides with POP.
                                rd_en <= (next_after_byte_s == POP);
                            end
                        end
                        default: phase <= TX_WAIT_IDLE;
                    endcase
                end
                POP: begin
                    state <= CAP;
                end
                CAP: begin
                    hold     <= rd_data;
                    cnt      <= cnt + CNT_ONE;
`ifdef DUMP_CHECKSUM_EN
                    checksum <= checksum + rd_data[15:8] + rd_data[7:0];
`endif
                    state    <= BYTE_HI;
                end
                DONE: begin
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_uart_dump.sv
// Scoreboard bench: two DUT instances (2-word and 1-word frames) with FIFO and UART-tx models.
module tb_sdram_uart_dump;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        recv_done = 1'b0;
    logic [7:0]  recv_data = 8'h00;
    logic        init_a = 1'b0, init_b = 1'b0;
    logic        stall = 1'b0;
    logic        rd_en_a, rd_en_b, send_en_a, send_en_b;
    logic        busy_a, busy_b, frame_done_a, frame_done_b;
    logic [7:0]  send_data_a, send_data_b;
    logic [15:0] rd_data_a = 16'hDEAD, rd_data_b = 16'hDEAD;
    logic        model_a = 1'b0, model_b = 1'b0;
    logic        tx_busy_a, tx_busy_b;

    int vectors = 0, miscompares = 0;
    int lat = 4;
    int sends_a = 0, sends_b = 0, pops_a = 0, pops_b = 0, frames_a = 0, frames_b = 0;
    int left_a = 0, left_b = 0;
    logic pend_a = 1'b0, pend_b = 1'b0, fd_prev_a = 1'b0, fd_prev_b = 1'b0;
    logic [7:0] held_a = 8'h00, held_b = 8'h00;
    logic [8:0]  exp_a[$], exp_b[$];
    logic [15:0] fifo_a[$], fifo_b[$];

    always #10 sys_clk = ~sys_clk;

    assign tx_busy_a = model_a | stall;
    assign tx_busy_b = model_b;

    sdram_uart_dump #(.WORDS_PER_FRAME(2), .CMD_BYTE(8'h52)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .recv_done(recv_done), .recv_data(recv_data),
        .sdram_init_done(init_a), .rd_en(rd_en_a), .rd_data(rd_data_a), .tx_busy(tx_busy_a),
        .send_en(send_en_a), .send_data(send_data_a), .busy(busy_a), .frame_done(frame_done_a));

    sdram_uart_dump #(.WORDS_PER_FRAME(1), .CMD_BYTE(8'h52)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .recv_done(recv_done), .recv_data(recv_data),
        .sdram_init_done(init_b), .rd_en(rd_en_b), .rd_data(rd_data_b), .tx_busy(tx_busy_b),
        .send_en(send_en_b), .send_data(send_data_b), .busy(busy_b), .frame_done(frame_done_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Instance A: FIFO model, transmitter model and output scoreboard.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            model_a = 1'b0; left_a = 0; pend_a = 1'b0; fd_prev_a = 1'b0; rd_data_a = 16'hDEAD;
        end else begin
            if (send_en_a) check("tx_idle_at_send_a", {31'd0, tx_busy_a}, 32'd0);
            if (fd_prev_a) check("busy_drop_a", {31'd0, busy_a}, 32'd0);
            fd_prev_a = frame_done_a;
            if (pend_a && fifo_a.size() > 0) rd_data_a = fifo_a.pop_front();
            else rd_data_a = 16'hDEAD;
            pend_a = rd_en_a;
            if (rd_en_a) pops_a++;
            if (model_a) begin
                if (send_data_a !== held_a) begin
                    miscompares++;
                    $display("FAIL tx_hold_a: got %0h, expected %0h", send_data_a, held_a);
                end
                left_a--;
                if (left_a <= 0) model_a = 1'b0;
            end
            if (send_en_a || frame_done_a) begin
                if (send_en_a) sends_a++;
                if (frame_done_a) begin
                    frames_a++;
                    check("busy_at_done_a", {31'd0, busy_a}, 32'd1);
                end
                if (exp_a.size() == 0) check("unexpected_out_a", {23'd0, frame_done_a, send_data_a}, 32'h1FF);
                else check("out_a", frame_done_a ? 32'h100 : {24'd0, send_data_a}, {23'd0, exp_a.pop_front()});
                if (send_en_a) begin held_a = send_data_a; model_a = 1'b1; left_a = lat; end
            end
        end
    end

    // Instance B: FIFO model, transmitter model and output scoreboard.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            model_b = 1'b0; left_b = 0; pend_b = 1'b0; fd_prev_b = 1'b0; rd_data_b = 16'hDEAD;
        end else begin
            if (send_en_b) check("tx_idle_at_send_b", {31'd0, tx_busy_b}, 32'd0);
            if (fd_prev_b) check("busy_drop_b", {31'd0, busy_b}, 32'd0);
            fd_prev_b = frame_done_b;
            if (pend_b && fifo_b.size() > 0) rd_data_b = fifo_b.pop_front();
            else rd_data_b = 16'hDEAD;
            pend_b = rd_en_b;
            if (rd_en_b) pops_b++;
            if (model_b) begin
                if (send_data_b !== held_b) begin
                    miscompares++;
                    $display("FAIL tx_hold_b: got %0h, expected %0h", send_data_b, held_b);
                end
                left_b--;
                if (left_b <= 0) model_b = 1'b0;
            end
            if (send_en_b || frame_done_b) begin
                if (send_en_b) sends_b++;
                if (frame_done_b) begin
                    frames_b++;
                    check("busy_at_done_b", {31'd0, busy_b}, 32'd1);
                end
                if (exp_b.size() == 0) check("unexpected_out_b", {23'd0, frame_done_b, send_data_b}, 32'h1FF);
                else check("out_b", frame_done_b ? 32'h100 : {24'd0, send_data_b}, {23'd0, exp_b.pop_front()});
                if (send_en_b) begin held_b = send_data_b; model_b = 1'b1; left_b = lat; end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(posedge sys_clk); #1;
        recv_done = 1'b1; recv_data = b;
        @(posedge sys_clk); #1;
        recv_done = 1'b0; recv_data = 8'h00;
    endtask

    task automatic wait_frame(input bit sel, input int target, input int budget);
        int n = 0;
        while (((sel ? frames_b : frames_a) < target) && (n < budget)) begin
            @(posedge sys_clk); #1;
            n++;
        end
        check(sel ? "frame_count_b" : "frame_count_a", sel ? frames_b : frames_a, target);
    endtask

    task automatic check_reset_outputs();
        check("rst_rd_en_a", {31'd0, rd_en_a}, 32'd0);
        check("rst_send_en_a", {31'd0, send_en_a}, 32'd0);
        check("rst_send_data_a", {24'd0, send_data_a}, 32'd0);
        check("rst_busy_a", {31'd0, busy_a}, 32'd0);
        check("rst_frame_done_a", {31'd0, frame_done_a}, 32'd0);
        check("rst_rd_en_b", {31'd0, rd_en_b}, 32'd0);
        check("rst_send_en_b", {31'd0, send_en_b}, 32'd0);
        check("rst_send_data_b", {24'd0, send_data_b}, 32'd0);
        check("rst_busy_b", {31'd0, busy_b}, 32'd0);
        check("rst_frame_done_b", {31'd0, frame_done_b}, 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_sends"}, sends_a + sends_b, 0);
        check({tag, "_pops"}, pops_a + pops_b, 0);
        check({tag, "_busy_a"}, {31'd0, busy_a}, 32'd0);
        check({tag, "_busy_b"}, {31'd0, busy_b}, 32'd0);
    endtask

    initial begin
        int base_pops, base_sends, n;
        wait_cycles(3);
        check_reset_outputs();
        sys_rst = 1'b0;
        wait_cycles(2);

        // Wrong command byte, then right byte with SDRAM not ready: nothing happens.
        init_a = 1'b1; init_b = 1'b1;
        send_cmd(8'h41);
        wait_cycles(40);
        check_quiet("ign41");
        init_a = 1'b0; init_b = 1'b0;
        send_cmd(8'h52);
        wait_cycles(40);
        check_quiet("noinit");

        // Two-word frame; transmitter busy at trigger, re-trigger and init drop mid-frame.
        init_a = 1'b1;
        fifo_a.push_back(16'h1234); fifo_a.push_back(16'hABCD);
        exp_a = '{9'h0A5, 9'h05A, 9'h012, 9'h034, 9'h0AB, 9'h0CD};
`ifdef DUMP_CHECKSUM_EN
        exp_a.push_back(9'h0BE);   // 12+34+AB+CD = 1BE
`endif
        exp_a.push_back(9'h100);
        stall = 1'b1;
        send_cmd(8'h52);
        wait_cycles(20);
        check("busy_mid_a", {31'd0, busy_a}, 32'd1);
        check("stalled_sends_a", sends_a, 0);
        stall = 1'b0;
        wait_cycles(15);
        send_cmd(8'h52);
        init_a = 1'b0;
        wait_frame(1'b0, 1, 2000);
        wait_cycles(10);
        check("pops_frame1_a", pops_a, 2);
        check("left_exp_a", exp_a.size(), 0);
        check("busy_idle_a", {31'd0, busy_a}, 32'd0);
        check("frames_no_queue_a", frames_a, 1);

        // Reset after the third byte aborts; the next trigger restarts from the header.
        init_a = 1'b1;
        base_sends = sends_a;
        fifo_a.push_back(16'h1234); fifo_a.push_back(16'hABCD);
        exp_a = '{9'h0A5, 9'h05A, 9'h012};
        send_cmd(8'h52);
        n = 0;
        while ((sends_a < base_sends + 3) && (n < 500)) begin
            @(posedge sys_clk); #1;
            n++;
        end
        check("third_byte_seen", sends_a - base_sends, 3);
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        check_reset_outputs();
        exp_a.delete(); fifo_a.delete();
        base_pops = pops_a;
        fifo_a.push_back(16'h0102); fifo_a.push_back(16'h0304);
        exp_a = '{9'h0A5, 9'h05A, 9'h001, 9'h002, 9'h003, 9'h004};
`ifdef DUMP_CHECKSUM_EN
        exp_a.push_back(9'h00A);
`endif
        exp_a.push_back(9'h100);
        send_cmd(8'h52);
        wait_frame(1'b0, 2, 2000);
        wait_cycles(5);
        check("pops_restart_a", pops_a - base_pops, 2);
        check("left_exp_restart_a", exp_a.size(), 0);

        // One-word frame of FFFF against a UART that stays busy 5208 cycles per byte.
        init_a = 1'b0; init_b = 1'b1;
        lat = 5208;
        base_sends = sends_a;
        fifo_b.push_back(16'hFFFF);
        exp_b = '{9'h0A5, 9'h05A, 9'h0FF, 9'h0FF};
`ifdef DUMP_CHECKSUM_EN
        exp_b.push_back(9'h0FE);
`endif
        exp_b.push_back(9'h100);
        send_cmd(8'h52);
        wait_frame(1'b1, 1, 40000);
        wait_cycles(5);
        check("pops_b", pops_b, 1);
`ifdef DUMP_CHECKSUM_EN
        check("sends_b", sends_b, 5);
`else
        check("sends_b", sends_b, 4);
`endif
        check("left_exp_b", exp_b.size(), 0);
        check("a_untouched", sends_a - base_sends, 0);
        check("busy_idle_b", {31'd0, busy_b}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
